// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: fetch slot record and instruction queue depth.
package mips_pkg;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic        en;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        pred;
        logic [31:0] jrtop;
        logic        tlb_refill;
        logic        tlb_invalid;
        logic        exception_instr;
    } fetch_data_t;

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer taking up to two slots
// per cycle (compacted) and presenting the two oldest entries to decode.
module instr_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  fetch_data_t [1:0] in_data,
    output logic             full,
    output fetch_data_t [1:0] out_data,
    output logic [1:0]       out_en,
    input  logic [1:0]       deq_num
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    fetch_data_t   mem [DEPTH];

    logic       push;
    logic [1:0] push_num, deq_c, pop_num;
    logic [AW:0] deq_ext;

    assign full    = count > (AW+1)'(DEPTH - 2);
    assign push    = in_valid && !full && !flush;
    assign deq_c   = (deq_num == 2'd3) ? 2'd2 : deq_num;
    assign deq_ext = {{(AW-1){1'b0}}, deq_c};
    // Over-asking decode only drains what is actually present.
    assign pop_num = (deq_ext > count) ? count[1:0] : deq_c;

    always_comb begin
        push_num = 2'd0;
        if (push) push_num = {1'b0, in_data[1].en} + {1'b0, in_data[0].en};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            assert (deq_num != 2'd3 && {{(AW-1){1'b0}}, deq_num} <= count)
                else $warning("instr_queue: deq_num %0d clamped, count %0d", deq_num, count);
            head  <= head + AW'(pop_num);
            tail  <= tail + AW'(push_num);
            count <= count + (AW+1)'(push_num) - (AW+1)'(pop_num);
        end
    end

    // Storage carries no reset; out_en masking keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            if (in_data[1].en && in_data[0].en) begin
                mem[tail]          <= in_data[1];
                mem[tail + AW'(1)] <= in_data[0];
            end else if (in_data[1].en) begin
                mem[tail] <= in_data[1];
            end else if (in_data[0].en) begin
                mem[tail] <= in_data[0];
            end
        end
    end

    always_comb begin
        out_en[1] = count != '0;
        out_en[0] = count > (AW+1)'(1);
        out_data  = '0;
        if (out_en[1]) begin
            out_data[1]    = mem[head];
            out_data[1].en = 1'b1;
        end
        if (out_en[0]) begin
            out_data[0]    = mem[head + AW'(1)];
            out_data[0].en = 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: vector table for control/flags plus a
// queue scoreboard tracking the stored slot contents.
module tb_instr_queue;
    import mips_pkg::*;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, full;
    fetch_data_t [1:0] in_data, out_data;
    logic [1:0]        out_en, deq_num;

    int total = 0;
    int bad   = 0;
    int pc_ctr = 0;
    fetch_data_t sb[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .full(full), .out_data(out_data),
        .out_en(out_en), .deq_num(deq_num)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] en;
        logic [1:0] dq;
        logic       fl;
        logic [1:0] exp_en;
        logic       exp_full;
    } vec_t;

    vec_t tv[15];

    function automatic fetch_data_t mk(input logic en);
        fetch_data_t d;
        d.en              = en;
        d.pc_plus4        = 32'h100 + 32'(4 * pc_ctr);
        d.instr           = $urandom;
        d.pred            = 1'($urandom);
        d.jrtop           = $urandom;
        d.tlb_refill      = 1'($urandom);
        d.tlb_invalid     = 1'($urandom);
        d.exception_instr = 1'($urandom);
        pc_ctr++;
        return d;
    endfunction

    task automatic chk1(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag);
        fetch_data_t e1, e0;
        e1 = '0;
        e0 = '0;
        if (sb.size() >= 1) begin e1 = sb[0]; e1.en = 1'b1; end
        if (sb.size() >= 2) begin e0 = sb[1]; e0.en = 1'b1; end
        chk1({tag, ".out1"}, 128'(out_data[1]), 128'(e1));
        chk1({tag, ".out0"}, 128'(out_data[0]), 128'(e0));
    endtask

    // One clock: drive, advance scoreboard alongside the DUT, sample #1 after.
    task automatic step(input logic v, input logic [1:0] en, input logic [1:0] dq,
                        input logic fl, input logic rs, input string tag);
        fetch_data_t d1, d0;
        logic full_pre;
        int n;
        d1 = mk(en[1]);
        d0 = mk(en[0]);
        in_valid = v; in_data[1] = d1; in_data[0] = d0;
        deq_num = dq; flush = fl; reset = rs;
        full_pre = sb.size() > DEPTH - 2;
        @(posedge clk);
        if (rs || fl) begin
            sb.delete();
        end else begin
            n = (dq == 2'd3) ? 2 : int'(dq);
            if (n > sb.size()) n = sb.size();
            repeat (n) void'(sb.pop_front());
            if (v && !full_pre) begin
                if (en[1]) sb.push_back(d1);
                if (en[0]) sb.push_back(d0);
            end
        end
        #1;
        check_out(tag);
    endtask

    initial begin
        tv[0]  = '{1'b1, 2'b11, 2'd0, 1'b0, 2'b11, 1'b0};
        tv[1]  = '{1'b1, 2'b11, 2'd0, 1'b0, 2'b11, 1'b0};
        tv[2]  = '{1'b1, 2'b11, 2'd0, 1'b0, 2'b11, 1'b0};
        tv[3]  = '{1'b1, 2'b11, 2'd0, 1'b0, 2'b11, 1'b1};
        tv[4]  = '{1'b1, 2'b11, 2'd0, 1'b0, 2'b11, 1'b1};
        tv[5]  = '{1'b0, 2'b00, 2'd2, 1'b0, 2'b11, 1'b0};
        tv[6]  = '{1'b1, 2'b10, 2'd0, 1'b0, 2'b11, 1'b1};
        tv[7]  = '{1'b1, 2'b11, 2'd2, 1'b0, 2'b11, 1'b0};
        tv[8]  = '{1'b1, 2'b01, 2'd1, 1'b0, 2'b11, 1'b0};
        tv[9]  = '{1'b1, 2'b11, 2'd2, 1'b1, 2'b00, 1'b0};
        tv[10] = '{1'b1, 2'b00, 2'd0, 1'b0, 2'b00, 1'b0};
        tv[11] = '{1'b1, 2'b10, 2'd0, 1'b0, 2'b10, 1'b0};
        tv[12] = '{1'b0, 2'b00, 2'd2, 1'b0, 2'b00, 1'b0};
        tv[13] = '{1'b1, 2'b11, 2'd0, 1'b0, 2'b11, 1'b0};
        tv[14] = '{1'b1, 2'b01, 2'd2, 1'b0, 2'b10, 1'b0};

        in_valid = 1'b0; in_data = '0; deq_num = 2'd0; flush = 1'b0; reset = 1'b1;
        step(1'b0, 2'b00, 2'd0, 1'b0, 1'b1, "reset");
        step(1'b0, 2'b00, 2'd0, 1'b0, 1'b1, "reset2");
        chk1("reset.out_en", 128'(out_en), 128'(2'b00));
        chk1("reset.full",   128'(full),   128'(1'b0));
        chk1("reset.data",   128'(out_data), 128'(0));
        pc_ctr = 0;

        for (int i = 0; i < 15; i++) begin
            step(tv[i].v, tv[i].en, tv[i].dq, tv[i].fl, 1'b0, $sformatf("vec%0d", i));
            chk1($sformatf("vec%0d.out_en", i), 128'(out_en), 128'(tv[i].exp_en));
            chk1($sformatf("vec%0d.full", i),   128'(full),   128'(tv[i].exp_full));
        end

        // Reset mid-stream beats a concurrent push.
        step(1'b1, 2'b11, 2'd0, 1'b0, 1'b0, "pre_rst");
        step(1'b1, 2'b11, 2'd1, 1'b1, 1'b1, "mid_rst");
        chk1("mid_rst.out_en", 128'(out_en), 128'(2'b00));
        chk1("mid_rst.full",   128'(full),   128'(1'b0));

        // Walk head and tail to 7, then push a pair straddling the wrap.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 2'b10, 2'd0, 1'b0, 1'b0, $sformatf("walk_push%0d", i));
            step(1'b0, 2'b00, 2'd1, 1'b0, 1'b0, $sformatf("walk_pop%0d", i));
        end
        chk1("walk.out_en", 128'(out_en), 128'(2'b00));
        step(1'b1, 2'b11, 2'd0, 1'b0, 1'b0, "wrap_push");
        chk1("wrap.out_en", 128'(out_en), 128'(2'b11));
        step(1'b0, 2'b00, 2'd1, 1'b0, 1'b0, "wrap_pop1");
        chk1("wrap_pop1.out_en", 128'(out_en), 128'(2'b10));
        step(1'b1, 2'b11, 2'd1, 1'b0, 1'b0, "wrap_mix");
        chk1("wrap_mix.out_en", 128'(out_en), 128'(2'b11));
        step(1'b0, 2'b00, 2'd2, 1'b0, 1'b0, "wrap_drain");
        chk1("wrap_drain.out_en", 128'(out_en), 128'(2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of instruction entries; power of two, >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  discard all entries (redirect or exception).
REQ-005 SHALL have port in_valid  input  1  fetch pair valid this cycle (fetch finished and not stalled).
REQ-006 SHALL have port in_data  input  fetch_data_t[1:0]  fetch pair; [1] older, [0] younger; per-slot .en marks presence.
REQ-007 SHALL have port full  output  1  fewer than 2 free entries; fetch stalls while high.
REQ-008 SHALL have port out_data  output  fetch_data_t[1:0]  two oldest entries; [1] oldest.
REQ-009 SHALL have port out_en  output  2  out_en[1]: >= 1 entry; out_en[0]: >= 2 entries.
REQ-010 SHALL have port deq_num  input  2  entries consumed by decode this cycle (0, 1, 2).

Function
REQ-011 SHALL be a circular buffer with head pointer, tail pointer (log2(DEPTH) bits, natural wrap) and count (log2(DEPTH)+1 bits).
REQ-012 SHALL push only when in_valid=1, full=0 and flush=0.
REQ-013 SHALL, on push with both en bits set, write in_data[1] at tail and in_data[0] at tail+1, then advance tail by 2.
REQ-014 SHALL, on push with exactly one en bit set, write that slot at tail and advance tail by 1 (compaction).
REQ-015 SHALL, on push with no en bit set, write nothing.
REQ-016 SHALL pop min(deq_num, count) entries by advancing head; a deq_num of 3 or a deq_num above count is clamped and flagged by a simulation assertion.
REQ-017 SHALL update count_next = count + pushed - popped in the same cycle when push and pop coincide; pop uses pre-update occupancy.
REQ-018 SHALL derive full combinationally from registered count: full = (count > DEPTH-2).
REQ-019 SHALL drive out_data[1] = entry[head] and out_data[0] = entry[head+1] from registered storage, with no bypass.
REQ-020 SHALL mask each out_data slot to '0 whenever its out_en bit is 0, and SHALL force out_data[k].en = out_en[k].
REQ-021 SHALL make a pushed entry visible on out_data one cycle after the push edge; latency is exactly 1 cycle.
REQ-022 SHALL store every field of fetch_data_t unmodified (pred, jrtop, TLB exception flags, exception_instr).
REQ-023 SHALL, on flush, zero head, tail and count at the next edge; flush beats push and pop in the same cycle.
REQ-024 SHALL accept the flush-cycle pair neither before nor after the flush.
REQ-025 SHALL wrap head and tail at DEPTH without an entry gap; a pair straddling the wrap writes entry DEPTH-1 and entry 0.

Reset
REQ-026 SHALL, with reset=1 at a rising edge, zero head, tail and count; the resulting outputs are out_en=2'b00, out_data='0, full=0.
REQ-027 SHALL give reset priority over flush, push and pop; reset mid-stream discards all entries.
REQ-028 SHALL leave storage unreset; REQ-020 masking keeps outputs deterministic.

Structure
REQ-029 SHALL take fetch_data_t from the shared mips package and add constant IQ_DEPTH (default 8) there for the instantiating top.
REQ-030 SHALL be a single module with storage as an inline register array; no sub-module is needed.

Verification
REQ-031 Reset, then push pair A(pc+4=0x100), B(0x104) -> next cycle out_en=11, out_data[1]=A, out_data[0]=B, count=2.
REQ-032 Push 4 pairs with deq_num=0, DEPTH=8 -> full=1 once count=7 or more; next push ignored; deq_num=2 -> full=0 next cycle.
REQ-033 Push pair with en=2'b10 (taken branch) then a full pair -> entries stored contiguous, count=3, no hole.
REQ-034 Count=1 and deq_num=2 -> one entry popped, count=0, out_en=00, assertion fires.
REQ-035 Head=tail=7, push pair -> entries land at 7 and 0; outputs correct across the wrap.
REQ-036 Count=5, flush with in_valid=1 and deq_num=2 -> next cycle count=0, out_en=00, full=0, pair not stored.
